quad_encoder_position: RTL and testbench

//  Sequential successor to the combinational count-to-position converter.

---
 rtl/quad_encoder_position.sv | 209 ++++++++++++++++++++
 tb/tb_quad_encoder_position.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_position.sv
// ============================================================================
// Module   : quad_encoder_position
// Brief    : Filtered x4 quadrature decoder with index and a multi-cycle
//            count-to-angle scaler (POSITION = COUNT * 2^POS_W / (PPR+1)).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module quad_encoder_position #(
  parameter int CNT_W    = 10,
  parameter int POS_W    = 10,
  parameter int FILT_LEN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  input  logic             z,
  input  logic [CNT_W-1:0] ppr,
  output logic [CNT_W-1:0] count,
  output logic             dir,
  output logic [POS_W-1:0] position,
  output logic             pos_valid,
  output logic             index_seen,
  output logic             err
);

  localparam int c_FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int c_IW = (POS_W > 1) ? $clog2(POS_W) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // bit order {a, b, z} throughout the input path
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] w_filt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {a, b, z};
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_filt
    logic [c_FW-1:0] r_fcnt;
    logic            r_out;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_fcnt <= '0;
        r_out  <= 1'b0;
      end else if (r_sync2[i] == r_out) begin
        r_fcnt <= '0;
      end else if (r_fcnt == c_FW'(FILT_LEN - 1)) begin
        r_out  <= r_sync2[i];
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end

    assign w_filt[i] = r_out;
  end

  logic [1:0] w_ab;
  logic       w_z;
  logic [1:0] r_prev_ab;
  logic       r_prev_z;
  logic       w_up;
  logic       w_dn;
  logic       w_illegal;
  logic       w_zrise;

  assign w_ab      = w_filt[2:1];
  assign w_z       = w_filt[0];
  assign w_illegal = ((r_prev_ab ^ w_ab) == 2'b11);
  assign w_zrise   = w_z & ~r_prev_z;

  always_comb begin
    w_up = 1'b0;
    w_dn = 1'b0;
    case ({r_prev_ab, w_ab})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: w_up = 1'b1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: w_dn = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count      <= '0;
      dir        <= 1'b0;
      index_seen <= 1'b0;
      err        <= 1'b0;
      r_prev_ab  <= '0;
      r_prev_z   <= 1'b0;
    end else begin
      r_prev_ab <= w_ab;
      r_prev_z  <= w_z;
      err       <= w_illegal;
      if (en) begin
        if (w_zrise) begin
          count      <= '0;
          index_seen <= 1'b1;
        end else if (w_up) begin
          // >= so a count stranded above a lowered PPR still wraps to 0
          count <= (count >= ppr) ? '0 : count + 1'b1;
          dir   <= 1'b1;
        end else if (w_dn) begin
          count <= (count == '0) ? ppr : count - 1'b1;
          dir   <= 1'b0;
        end
      end
    end
  end

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_last_count;
  logic [CNT_W-1:0] r_last_ppr;
  logic             r_pending;
  logic [c_IW-1:0]  r_iter;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W:0]   r_div;
  logic [POS_W-1:0] r_q;
  logic             w_changed;
  logic             w_start;
  logic             w_last_iter;
  logic [CNT_W:0]   w_shift;
  logic             w_ge;
  logic [CNT_W:0]   w_rem_nxt;
  logic             w_unused;

  assign w_changed   = (count != r_last_count) || (ppr != r_last_ppr);
  assign w_start     = (r_state == ST_IDLE) && (w_changed || r_pending);
  assign w_last_iter = (r_iter == c_IW'(POS_W - 1));
  assign w_shift     = {r_rem, 1'b0};
  assign w_ge        = (w_shift >= r_div);
  // remainder stays below div <= 2^CNT_W, so the top bit is always zero
  assign w_rem_nxt   = w_ge ? (w_shift - r_div) : w_shift;
  assign w_unused    = w_rem_nxt[CNT_W];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_next = ST_CALC;
      ST_CALC: if (w_last_iter) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_count <= '0;
      r_last_ppr   <= '0;
      r_pending    <= 1'b0;
      r_iter       <= '0;
      r_rem        <= '0;
      r_div        <= '0;
      r_q          <= '0;
      position     <= '0;
      pos_valid    <= 1'b0;
    end else begin
      pos_valid <= 1'b0;
      if (r_state != ST_IDLE && w_changed) r_pending <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_last_count <= count;
            r_last_ppr   <= ppr;
            r_pending    <= 1'b0;
            r_rem        <= (count > ppr) ? ppr : count;
            r_div        <= {1'b0, ppr} + 1'b1;
            r_iter       <= '0;
            r_q          <= '0;
          end
        end
        ST_CALC: begin
          r_rem  <= w_rem_nxt[CNT_W-1:0];
          r_q    <= (r_q << 1) | POS_W'(w_ge);
          r_iter <= r_iter + 1'b1;
        end
        ST_DONE: begin
          position  <= r_q;
          pos_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_quad_encoder_position.sv
// ============================================================================
// Module   : tb_quad_encoder_position
// Brief    : Directed bench for quad_encoder_position (FILT_LEN=3, 10-bit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_quad_encoder_position;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       a;
  logic       b;
  logic       z;
  logic [9:0] ppr;
  logic [9:0] count;
  logic       dir;
  logic [9:0] position;
  logic       pos_valid;
  logic       index_seen;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int ph       = 0;

  always #5 clk = ~clk;

  quad_encoder_position #(.CNT_W(10), .POS_W(10), .FILT_LEN(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .z(z), .ppr(ppr),
    .count(count), .dir(dir), .position(position), .pos_valid(pos_valid),
    .index_seen(index_seen), .err(err)
  );

  always @(negedge clk) begin
    if (pos_valid) n_valid <= n_valid + 1;
    if (err)       n_err   <= n_err + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_ph();
    case (ph)
      0: {a, b} = 2'b00;
      1: {a, b} = 2'b01;
      2: {a, b} = 2'b11;
      default: {a, b} = 2'b10;
    endcase
  endtask

  task automatic step(input int up, input int hold);
    ph = up ? (ph + 1) % 4 : (ph + 3) % 4;
    drive_ph();
    idle(hold);
  endtask

  int v0;
  int e0;

  initial begin
    rst_n = 1'b0; en = 1'b1; a = 1'b0; b = 1'b0; z = 1'b0; ppr = 10'd599;
    idle(5);
    check("rst_count", count, 0);
    check("rst_dir", dir, 0);
    check("rst_position", position, 0);
    check("rst_pos_valid", pos_valid, 0);
    check("rst_index_seen", index_seen, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    idle(30);

    v0 = n_valid;
    repeat (400) step(1, 8);
    idle(40);
    check("t1_count", count, 400);
    check("t1_position", position, 682);
    check("t1_dir", dir, 1);
    check("t1_valid_seen", int'(n_valid > v0), 1);

    step(1, 8);
    idle(40);
    check("t2_pos401", position, 684);
    repeat (301) step(0, 8);
    idle(40);
    check("t2_count100", count, 100);
    check("t2_pos100", position, 170);
    ppr = 10'd1023;
    idle(40);
    check("t2_pos_ppr1023", position, 100);
    ppr = 10'd599;
    idle(40);

    repeat (499) step(1, 8);
    idle(40);
    check("t3_count599", count, 599);
    step(1, 8);
    idle(4);
    check("t3_wrap_up", count, 0);
    check("t3_dir_up", dir, 1);
    step(0, 8);
    idle(4);
    check("t3_wrap_dn", count, 599);
    check("t3_dir_dn", dir, 0);

    e0 = n_err;
    ph = (ph + 2) % 4;
    drive_ph();
    idle(10);
    check("t4_err_pulse1", n_err - e0, 1);
    check("t4_count_hold1", count, 599);
    ph = (ph + 2) % 4;
    drive_ph();
    idle(10);
    check("t4_err_pulse2", n_err - e0, 2);
    check("t4_count_hold2", count, 599);
    a = ~a;
    idle(2);
    a = ~a;
    idle(12);
    check("t4_glitch_count", count, 599);
    check("t4_glitch_err", n_err - e0, 2);
    check("t4_glitch_dir", dir, 0);

    repeat (349) step(0, 8);
    idle(40);
    check("t5_count250", count, 250);
    check("t5_index_pre", index_seen, 0);
    z = 1'b1;
    step(1, 10);
    z = 1'b0;
    idle(40);
    check("t5_count_idx", count, 0);
    check("t5_index_seen", index_seen, 1);
    check("t5_position", position, 0);

    v0 = n_valid;
    repeat (3) step(1, 4);
    idle(60);
    check("t6_count", count, 3);
    check("t6_position", position, 5);
    check("t6_conversions", n_valid - v0, 2);

    v0 = n_valid;
    step(1, 8);
    rst_n = 1'b0;
    idle(3);
    check("t6_rst_count", count, 0);
    check("t6_rst_position", position, 0);
    check("t6_rst_pos_valid", pos_valid, 0);
    check("t6_rst_index", index_seen, 0);
    check("t6_rst_dir", dir, 0);
    check("t6_rst_err", err, 0);
    check("t6_rst_no_valid", n_valid - v0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
